// File: rtl/ddr_dummy_responder.sv
// Behavioural DDR stand-in: accepts one command at a time, answers after LATENCY cycles,
// and keeps written lines in a small fully associative table with round-robin replacement.
module ddr_dummy_responder #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned ENTRIES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] mem_data_wr,
  output logic [255:0] mem_data_rd,
  input  logic [27:0]  mem_data_addr,
  input  logic         mem_rw_data,
  input  logic         mem_valid_data,
  output logic         mem_ready_data,
  output logic         rd_miss,
  output logic         overflow,
  output logic         proto_err,
  output logic [15:0]  wr_count,
  output logic [15:0]  rd_count
);

  localparam int unsigned IdxW = $clog2(ENTRIES);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e              state_q;
  logic [5:0]          cnt_q;
  logic [27:0]         addr_q;
  logic                rw_q;
  logic [255:0]        wdata_q;
  logic [ENTRIES-1:0]  valid_q;
  logic [27:0]         tag_q  [ENTRIES];
  logic [255:0]        data_q [ENTRIES];
  logic [IdxW-1:0]     ptr_q;

  logic            commit;
  logic            hit, free;
  logic [IdxW-1:0] hit_idx, free_idx, wr_idx;

  assign commit = (state_q == StBusy) && (cnt_q == 6'(LATENCY - 1));

  // Lowest index wins for both the hit match and the free-slot search.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!hit && valid_q[i] && (tag_q[i] == addr_q)) begin
        hit     = 1'b1;
        hit_idx = IdxW'(i);
      end
      if (!free && !valid_q[i]) begin
        free     = 1'b1;
        free_idx = IdxW'(i);
      end
    end
    wr_idx = hit ? hit_idx : (free ? free_idx : ptr_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      addr_q         <= '0;
      rw_q           <= 1'b0;
      wdata_q        <= '0;
      valid_q        <= '0;
      ptr_q          <= '0;
      mem_ready_data <= 1'b0;
      mem_data_rd    <= '0;
      rd_miss        <= 1'b0;
      overflow       <= 1'b0;
      proto_err      <= 1'b0;
      wr_count       <= '0;
      rd_count       <= '0;
    end else begin
      mem_ready_data <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (mem_valid_data) begin
            addr_q  <= mem_data_addr;
            rw_q    <= mem_rw_data;
            wdata_q <= mem_data_wr;
            cnt_q   <= '0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (!mem_valid_data) proto_err <= 1'b1;
          if (commit) begin
            state_q        <= StResp;
            mem_ready_data <= 1'b1;
            if (rw_q) begin
              valid_q[wr_idx] <= 1'b1;
              wr_count        <= wr_count + 16'd1;
              if (!hit && !free) begin
                overflow <= 1'b1;
                ptr_q    <= (ptr_q == IdxW'(ENTRIES - 1)) ? '0 : ptr_q + 1'b1;
              end
            end else begin
              rd_count <= rd_count + 16'd1;
              if (hit) begin
                mem_data_rd <= data_q[hit_idx];
              end else begin
                mem_data_rd <= '0;
                rd_miss     <= 1'b1;
              end
            end
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        // Valid is deliberately ignored here so a held command is not taken twice.
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Tag/data storage needs no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (rst && commit && rw_q) begin
      tag_q[wr_idx]  <= addr_q;
      data_q[wr_idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_ddr_dummy_responder.sv
// Directed bench for ddr_dummy_responder with LATENCY=4, ENTRIES=16.
module tb_ddr_dummy_responder;

  logic         clk;
  logic         rst;
  logic [255:0] mem_data_wr;
  logic [255:0] mem_data_rd;
  logic [27:0]  mem_data_addr;
  logic         mem_rw_data;
  logic         mem_valid_data;
  logic         mem_ready_data;
  logic         rd_miss;
  logic         overflow;
  logic         proto_err;
  logic [15:0]  wr_count;
  logic [15:0]  rd_count;

  int checks   = 0;
  int failures = 0;

  ddr_dummy_responder #(
    .LATENCY(4),
    .ENTRIES(16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_data_wr   (mem_data_wr),
    .mem_data_rd   (mem_data_rd),
    .mem_data_addr (mem_data_addr),
    .mem_rw_data   (mem_rw_data),
    .mem_valid_data(mem_valid_data),
    .mem_ready_data(mem_ready_data),
    .rd_miss       (rd_miss),
    .overflow      (overflow),
    .proto_err     (proto_err),
    .wr_count      (wr_count),
    .rd_count      (rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [255:0] D1 = {2{128'h11112222333344445555666677778888}};
  localparam logic [255:0] D2 = {8{32'hDEADBEEF}};
  localparam logic [255:0] D3 = {4{64'h0123456789ABCDEF}};

  typedef struct {
    logic         rw;
    logic [27:0]  addr;
    logic [255:0] wd;
    logic [255:0] erd;
    logic         emiss;
    logic [15:0]  ewc;
    logic [15:0]  erc;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] dat(input int i);
    return {8{32'hA000_0000 + 32'(i)}};
  endfunction

  // Issue one command; returns negedges from drive to ready (0 on timeout) and read data.
  task automatic run_cmd(input logic rw, input logic [27:0] a, input logic [255:0] d,
                         input bit drop, output int lat, output logic [255:0] rdata);
    lat   = 0;
    rdata = '0;
    mem_rw_data    = rw;
    mem_data_addr  = a;
    mem_data_wr    = d;
    mem_valid_data = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (drop && n == 1) mem_valid_data = 1'b0;
      if (n == 2) begin
        mem_data_addr = ~a;
        mem_rw_data   = ~rw;
        mem_data_wr   = ~d;
      end
      if (mem_ready_data) begin
        lat   = n;
        rdata = mem_data_rd;
        break;
      end
    end
    // Valid stays high across the edge that ends the ready cycle.
    @(negedge clk);
    chk("ready_single_cycle", {255'b0, mem_ready_data}, 256'd0);
    mem_valid_data = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  int           lat;
  logic [255:0] rdata;
  int           npulse, first, prev;
  bit           seen;

  initial begin
    vt[0] = '{1'b1, 28'h0000008, D1, 256'd0, 1'b0, 16'd1, 16'd0};
    vt[1] = '{1'b0, 28'h0000008, 256'd0, D1, 1'b0, 16'd1, 16'd1};
    vt[2] = '{1'b0, 28'h2400030, 256'd0, 256'd0, 1'b1, 16'd1, 16'd2};
    vt[3] = '{1'b1, 28'h0000010, D2, 256'd0, 1'b1, 16'd2, 16'd2};
    vt[4] = '{1'b0, 28'h0000008, 256'd0, D1, 1'b1, 16'd2, 16'd3};
    vt[5] = '{1'b1, 28'h0000008, D3, D1, 1'b1, 16'd3, 16'd3};
    vt[6] = '{1'b0, 28'h0000008, 256'd0, D3, 1'b1, 16'd3, 16'd4};
    vt[7] = '{1'b0, 28'h0000010, 256'd0, D2, 1'b1, 16'd3, 16'd5};

    rst = 1'b0;
    mem_valid_data = 1'b0;
    mem_rw_data = 1'b0;
    mem_data_addr = '0;
    mem_data_wr = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {255'b0, mem_ready_data}, 256'd0);
    chk("rst_rd", mem_data_rd, 256'd0);
    chk("rst_flags", {253'b0, rd_miss, overflow, proto_err}, 256'd0);
    chk("rst_counts", {224'b0, wr_count, rd_count}, 256'd0);

    // Command presented on the last reset edge must not be accepted there.
    mem_rw_data = 1'b1;
    mem_data_addr = vt[0].addr;
    mem_data_wr = vt[0].wd;
    mem_valid_data = 1'b1;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_cmd(vt[i].rw, vt[i].addr, vt[i].wd, 1'b0, lat, rdata);
      chk($sformatf("v%0d_latency", i), lat, 5);
      chk($sformatf("v%0d_rd_data", i), rdata, vt[i].erd);
      chk($sformatf("v%0d_rd_miss", i), {255'b0, rd_miss}, {255'b0, vt[i].emiss});
      chk($sformatf("v%0d_wr_count", i), {240'b0, wr_count}, {240'b0, vt[i].ewc});
      chk($sformatf("v%0d_rd_count", i), {240'b0, rd_count}, {240'b0, vt[i].erc});
      chk($sformatf("v%0d_overflow", i), {255'b0, overflow}, 256'd0);
    end

    seen = 1'b0;
    repeat (7) begin
      @(negedge clk);
      if (mem_ready_data) seen = 1'b1;
    end
    chk("idle_no_ready", {255'b0, seen}, 256'd0);
    chk("idle_wr_count", {240'b0, wr_count}, 256'd3);

    // Reset two cycles into BUSY discards the in-flight write.
    mem_rw_data = 1'b1;
    mem_data_addr = 28'h0000020;
    mem_data_wr = D2;
    mem_valid_data = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mem_valid_data = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mid_rst_ready", {255'b0, mem_ready_data}, 256'd0);
    chk("mid_rst_rd", mem_data_rd, 256'd0);
    chk("mid_rst_flags", {253'b0, rd_miss, overflow, proto_err}, 256'd0);
    chk("mid_rst_counts", {224'b0, wr_count, rd_count}, 256'd0);
    seen = 1'b0;
    repeat (7) begin
      @(negedge clk);
      if (mem_ready_data) seen = 1'b1;
    end
    chk("mid_rst_no_ready", {255'b0, seen}, 256'd0);
    run_cmd(1'b0, 28'h0000020, '0, 1'b0, lat, rdata);
    chk("post_rst_latency", lat, 5);
    chk("post_rst_rd", rdata, 256'd0);
    chk("post_rst_miss", {255'b0, rd_miss}, 256'd1);
    run_cmd(1'b0, 28'h0000008, '0, 1'b0, lat, rdata);
    chk("post_rst_old_line", rdata, 256'd0);

    // Fill all 16 slots, then a 17th write replaces slot 0.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      run_cmd(1'b1, 28'h0000100 + 28'(i), dat(i), 1'b0, lat, rdata);
      if (i == 15) chk("ovf_after_16", {255'b0, overflow}, 256'd0);
    end
    chk("ovf_after_17", {255'b0, overflow}, 256'd1);
    chk("ovf_wr_count", {240'b0, wr_count}, 256'd17);
    run_cmd(1'b0, 28'h0000110, '0, 1'b0, lat, rdata);
    chk("ovf_rd_17th", rdata, dat(16));
    chk("ovf_no_miss_yet", {255'b0, rd_miss}, 256'd0);
    run_cmd(1'b0, 28'h0000100, '0, 1'b0, lat, rdata);
    chk("ovf_rd_1st", rdata, 256'd0);
    chk("ovf_miss", {255'b0, rd_miss}, 256'd1);
    run_cmd(1'b0, 28'h0000101, '0, 1'b0, lat, rdata);
    chk("ovf_rd_2nd", rdata, dat(1));

    // Valid held continuously: one pulse every LATENCY+2 cycles.
    mem_valid_data = 1'b1;
    mem_rw_data = 1'b0;
    mem_data_addr = 28'h0000101;
    npulse = 0;
    first = 0;
    prev = 0;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      if (mem_ready_data) begin
        if (npulse == 0) first = n;
        else chk("tp_gap", n - prev, 6);
        prev = n;
        npulse++;
        chk("tp_rd", mem_data_rd, dat(1));
      end
    end
    mem_valid_data = 1'b0;
    chk("tp_first", first, 5);
    chk("tp_pulses", npulse, 3);
    chk("tp_no_proto_err", {255'b0, proto_err}, 256'd0);

    run_cmd(1'b0, 28'h0000101, '0, 1'b1, lat, rdata);
    chk("drop_latency", lat, 5);
    chk("drop_rd", rdata, dat(1));
    chk("drop_proto_err", {255'b0, proto_err}, 256'd1);
    chk("final_rd_count", {240'b0, rd_count}, 256'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
